// File: rtl/pipe_mem_arbiter.sv
// Arbitrates IF/MEM stage requests onto one single-port memory bus.
// Ports: clk/reset; if_* fetch side; mem_* load/store side; ext_* memory bus; err_o.
module pipe_mem_arbiter #(
  parameter int STARVE_LIMIT = 3,
  parameter int TIMEOUT      = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_ack_o,
  output logic [31:0] if_rdata_o,
  input  logic        mem_req_i,
  input  logic        mem_wr_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic        mem_ack_o,
  output logic [31:0] mem_rdata_o,
  output logic        err_o,
  output logic        ext_req_o,
  output logic        ext_wr_o,
  output logic [31:0] ext_addr_o,
  output logic [31:0] ext_wdata_o,
  input  logic [31:0] ext_rdata_i,
  input  logic        ext_ready_i
);

  localparam int SW_RAW = $clog2(STARVE_LIMIT + 1);
  localparam int SW     = (SW_RAW < 2) ? 2 : SW_RAW;
  localparam int WW_RAW = $clog2(TIMEOUT + 1);
  localparam int WW     = (WW_RAW < 1) ? 1 : WW_RAW;

  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);
  localparam logic [31:0]   ERR_WORD   = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_BUSY_IF  = 2'd1,
    S_BUSY_MEM = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic          r_if_ack;
  logic          r_mem_ack;
  logic          r_err;
  logic [31:0]   r_if_rdata;
  logic [31:0]   r_mem_rdata;
  logic          r_ext_req;
  logic          r_ext_wr;
  logic [31:0]   r_ext_addr;
  logic [31:0]   r_ext_wdata;
  logic [SW-1:0] r_starve;
  logic [WW-1:0] r_wait;

  logic w_pick_mem;
  logic w_pick_if;
  logic w_grant_if;
  logic w_grant_mem;
  logic w_done;
  logic w_tmo;
  logic w_ack_cyc;

  // MEM wins ties until IF has lost STARVE_LIMIT times in a row.
  assign w_pick_mem = mem_req_i &
                      (~if_req_i | (r_starve != STARVE_MAX));
  assign w_pick_if  = if_req_i & ~w_pick_mem;
  // The held request is still high while its ack shows; skip a cycle.
  assign w_ack_cyc  = r_if_ack | r_mem_ack;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_if  = 1'b0;
    w_grant_mem = 1'b0;
    w_done      = 1'b0;
    w_tmo       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_ack_cyc) begin
          unique case (1'b1)
            w_pick_mem: begin
              w_grant_mem = 1'b1;
              w_state_nxt = S_BUSY_MEM;
            end
            w_pick_if: begin
              w_grant_if  = 1'b1;
              w_state_nxt = S_BUSY_IF;
            end
            default: ;
          endcase
        end
      end
      S_BUSY_IF, S_BUSY_MEM: begin
        // A ready in the last allowed cycle beats the timeout.
        if (ext_ready_i) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_wait == WAIT_LAST) begin
          w_tmo       = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_if_ack    <= 1'b0;
      r_mem_ack   <= 1'b0;
      r_err       <= 1'b0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
      r_ext_req   <= 1'b0;
      r_ext_wr    <= 1'b0;
      r_ext_addr  <= '0;
      r_ext_wdata <= '0;
      r_starve    <= '0;
      r_wait      <= '0;
    end else begin
      r_if_ack  <= 1'b0;
      r_mem_ack <= 1'b0;
      r_err     <= 1'b0;
      if (w_grant_if) begin
        r_ext_req   <= 1'b1;
        r_ext_wr    <= 1'b0;
        r_ext_addr  <= if_addr_i;
        r_ext_wdata <= '0;
        r_wait      <= '0;
        r_starve    <= '0;
      end
      if (w_grant_mem) begin
        r_ext_req   <= 1'b1;
        r_ext_wr    <= mem_wr_i;
        r_ext_addr  <= mem_addr_i;
        r_ext_wdata <= mem_wdata_i;
        r_wait      <= '0;
        if (if_req_i && (r_starve != STARVE_MAX))
          r_starve <= r_starve + 1'b1;
      end
      if (w_done || w_tmo) begin
        r_ext_req <= 1'b0;
        r_err     <= w_tmo;
        if (r_state == S_BUSY_IF) begin
          r_if_ack   <= 1'b1;
          r_if_rdata <= w_tmo ? ERR_WORD : ext_rdata_i;
        end else begin
          r_mem_ack <= 1'b1;
          if (!r_ext_wr)
            r_mem_rdata <= w_tmo ? ERR_WORD : ext_rdata_i;
        end
      end else if (r_state != S_IDLE) begin
        r_wait <= r_wait + 1'b1;
      end
    end
  end

  assign if_ack_o    = r_if_ack;
  assign if_rdata_o  = r_if_rdata;
  assign mem_ack_o   = r_mem_ack;
  assign mem_rdata_o = r_mem_rdata;
  assign err_o       = r_err;
  assign ext_req_o   = r_ext_req;
  assign ext_wr_o    = r_ext_wr;
  assign ext_addr_o  = r_ext_addr;
  assign ext_wdata_o = r_ext_wdata;

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Testbench for pipe_mem_arbiter: directed table, random transactions
// against a transaction-level model, and reset-during-access sequence.
module tb_pipe_mem_arbiter;

  localparam int STARVE_LIMIT = 3;
  localparam int TIMEOUT      = 15;
  localparam logic [31:0] ERRW = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_ack_o;
  logic [31:0] if_rdata_o;
  logic        mem_req_i;
  logic        mem_wr_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic        mem_ack_o;
  logic [31:0] mem_rdata_o;
  logic        err_o;
  logic        ext_req_o;
  logic        ext_wr_o;
  logic [31:0] ext_addr_o;
  logic [31:0] ext_wdata_o;
  logic [31:0] ext_rdata_i;
  logic        ext_ready_i;

  pipe_mem_arbiter #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .if_req_i   (if_req_i),
    .if_addr_i  (if_addr_i),
    .if_ack_o   (if_ack_o),
    .if_rdata_o (if_rdata_o),
    .mem_req_i  (mem_req_i),
    .mem_wr_i   (mem_wr_i),
    .mem_addr_i (mem_addr_i),
    .mem_wdata_i(mem_wdata_i),
    .mem_ack_o  (mem_ack_o),
    .mem_rdata_o(mem_rdata_o),
    .err_o      (err_o),
    .ext_req_o  (ext_req_o),
    .ext_wr_o   (ext_wr_o),
    .ext_addr_o (ext_addr_o),
    .ext_wdata_o(ext_wdata_o),
    .ext_rdata_i(ext_rdata_i),
    .ext_ready_i(ext_ready_i)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // reference model state
  int          starve   = 0;
  logic [31:0] m_if_rd  = '0;
  logic [31:0] m_mem_rd = '0;
  bit          after_ack = 1'b0;

  typedef struct {
    bit          ifr;
    bit          memr;
    bit          wr;
    logic [31:0] ia;
    logic [31:0] ma;
    logic [31:0] wd;
    logic [31:0] rd;
    int          d;
    bit          e_if;
    bit          e_err;
    logic [31:0] e_rd;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ext_req"}, 32'(ext_req_o), 0);
    chk({tag, "_ext_wr"}, 32'(ext_wr_o), 0);
    chk({tag, "_ext_addr"}, ext_addr_o, 0);
    chk({tag, "_ext_wdata"}, ext_wdata_o, 0);
    chk({tag, "_if_ack"}, 32'(if_ack_o), 0);
    chk({tag, "_mem_ack"}, 32'(mem_ack_o), 0);
    chk({tag, "_err"}, 32'(err_o), 0);
    chk({tag, "_if_rdata"}, if_rdata_o, 0);
    chk({tag, "_mem_rdata"}, mem_rdata_o, 0);
  endtask

  // Requests are already set up at a falling edge. The memory answers
  // in BUSY cycle d+1; with d+1 > TIMEOUT it never answers.
  task automatic txn(input bit e_if, input int d,
                     input logic [31:0] rd, input bit drop,
                     input bit e_err, input logic [31:0] e_rd);
    int          g;
    int          c_end;
    logic [31:0] w_addr;
    logic        w_wr;
    logic [31:0] w_wd;
    w_addr = e_if ? if_addr_i : mem_addr_i;
    w_wr   = e_if ? 1'b0 : mem_wr_i;
    w_wd   = e_if ? 32'h0 : mem_wdata_i;
    if (e_if) starve = 0;
    else if (if_req_i && starve < STARVE_LIMIT) starve++;
    for (g = 1; g <= 4; g++) begin
      @(negedge clk);
      if (ext_req_o) break;
      chk("idle_acks", {30'b0, if_ack_o, mem_ack_o}, 0);
    end
    chk("grant_cycle", g, after_ack ? 2 : 1);
    if (!ext_req_o) return;
    chk("ext_addr", ext_addr_o, w_addr);
    chk("ext_wr", 32'(ext_wr_o), 32'(w_wr));
    chk("ext_wdata", ext_wdata_o, w_wd);
    if (drop) begin
      if (e_if) if_req_i = 1'b0;
      else      mem_req_i = 1'b0;
    end
    c_end = (d + 1 < TIMEOUT) ? d + 1 : TIMEOUT;
    for (int c = 1; c <= c_end; c++) begin
      ext_ready_i = (c == d + 1);
      ext_rdata_i = (c == d + 1) ? rd : $urandom;
      @(negedge clk);
      if (c < c_end) begin
        chk("busy_req", 32'(ext_req_o), 1);
        chk("busy_acks",
            {29'b0, if_ack_o, mem_ack_o, err_o}, 0);
        chk("busy_addr", ext_addr_o, w_addr);
        chk("busy_wr", 32'(ext_wr_o), 32'(w_wr));
      end
    end
    ext_ready_i = 1'b0;
    chk("if_ack", 32'(if_ack_o), 32'(e_if));
    chk("mem_ack", 32'(mem_ack_o), 32'(!e_if));
    chk("err", 32'(err_o), 32'(e_err));
    chk("done_req", 32'(ext_req_o), 0);
    if (e_if) m_if_rd = e_rd;
    else if (!w_wr) m_mem_rd = e_rd;
    chk("if_rdata", if_rdata_o, m_if_rd);
    chk("mem_rdata", mem_rdata_o, m_mem_rd);
    if (e_if) if_req_i = 1'b0;
    else      mem_req_i = 1'b0;
    after_ack = 1'b1;
  endtask

  task automatic rand_txn();
    int          r;
    int          d;
    bit          e_if;
    bit          e_err;
    logic [31:0] rd;
    if (!if_req_i && ($urandom % 2 == 1)) begin
      if_req_i  = 1'b1;
      if_addr_i = $urandom;
    end
    if (!mem_req_i && ($urandom % 2 == 1)) begin
      mem_req_i   = 1'b1;
      mem_addr_i  = $urandom;
      mem_wr_i    = ($urandom % 2) == 1;
      mem_wdata_i = $urandom;
    end
    if (!if_req_i && !mem_req_i) begin
      if_req_i  = 1'b1;
      if_addr_i = $urandom;
    end
    e_if = if_req_i &&
           (!mem_req_i || starve == STARVE_LIMIT);
    r = int'($urandom % 8);
    d = (r < 5) ? r : int'($urandom_range(17, 13));
    e_err = (d + 1 > TIMEOUT);
    rd = $urandom;
    txn(e_if, d, rd, ($urandom % 4) == 0, e_err,
        e_err ? ERRW : rd);
  endtask

  initial begin
    tbl[0]  = '{1,0,0,32'h00400000,0,0,32'h8C080004,0,1,0,32'h8C080004};
    tbl[1]  = '{1,1,0,32'h00400010,32'h10000000,0,32'h11,0,0,0,32'h11};
    tbl[2]  = '{1,1,0,32'h00400010,32'h10000004,0,32'h22,0,0,0,32'h22};
    tbl[3]  = '{1,1,0,32'h00400010,32'h10000008,0,32'h33,0,0,0,32'h33};
    tbl[4]  = '{1,1,0,32'h00400010,32'h1000000C,0,32'h44,0,1,0,32'h44};
    tbl[5]  = '{1,1,0,32'h00400014,32'h1000000C,0,32'h55,0,0,0,32'h55};
    tbl[6]  = '{1,0,0,32'h00400014,0,0,32'h66,1,1,0,32'h66};
    tbl[7]  = '{0,1,1,0,32'h10010000,32'h12345678,32'h77,3,0,0,32'h0};
    tbl[8]  = '{0,1,0,0,32'h10010004,0,32'h88,20,0,1,ERRW};
    tbl[9]  = '{1,0,0,32'h00400020,0,0,32'hCAFEF00D,14,1,0,32'hCAFEF00D};
    tbl[10] = '{0,1,0,0,32'h10010008,0,32'h99,15,0,1,ERRW};

    reset       = 1'b1;
    if_req_i    = 1'b0;
    if_addr_i   = '0;
    mem_req_i   = 1'b0;
    mem_wr_i    = 1'b0;
    mem_addr_i  = '0;
    mem_wdata_i = '0;
    ext_rdata_i = '0;
    ext_ready_i = 1'b0;
    #12;
    chk_reset("por");
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i]) begin
      if_req_i    = tbl[i].ifr;
      mem_req_i   = tbl[i].memr;
      mem_wr_i    = tbl[i].wr;
      if_addr_i   = tbl[i].ia;
      mem_addr_i  = tbl[i].ma;
      mem_wdata_i = tbl[i].wd;
      txn(tbl[i].e_if, tbl[i].d, tbl[i].rd, 1'b0,
          tbl[i].e_err, tbl[i].e_rd);
    end

    for (int k = 0; k < 60; k++) rand_txn();

    // reset in the middle of a fetch
    mem_req_i = 1'b0;
    if_req_i  = 1'b1;
    if_addr_i = 32'h00400100;
    for (int g = 0; g < 4; g++) begin
      @(negedge clk);
      if (ext_req_o) break;
    end
    chk("rst_grant", 32'(ext_req_o), 1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk_reset("mid");
    if_req_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rst_no_ack", {30'b0, if_ack_o, ext_req_o}, 0);
    end
    @(negedge clk);
    reset     = 1'b0;
    starve    = 0;
    m_if_rd   = '0;
    m_mem_rd  = '0;
    after_ack = 1'b0;
    if_req_i    = 1'b1;
    if_addr_i   = 32'h00400200;
    mem_req_i   = 1'b1;
    mem_wr_i    = 1'b0;
    mem_addr_i  = 32'h10020000;
    for (int k = 0; k < 4; k++) rand_txn();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
